// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI rendezvous receive path: packet types,
// header layout and the receive FSM states.
package mpi_pkg;

  localparam logic [7:0] SYNC_ENV               = 8'd0;
  localparam logic [7:0] CLR2SND                = 8'd1;
  localparam logic [7:0] DATA                   = 8'd2;
  localparam logic [7:0] ASYNC_ENV              = 8'd3;
  localparam logic [7:0] RECV_ERROR             = 8'd4;
  localparam logic [7:0] DATA_TRANSMISSION_DONE = 8'd5;

  localparam logic [7:0] MPI_VERSION = 8'd1;

  // First beat of every frame; field order is MSB first.
  typedef struct packed {
    logic [7:0]  version;
    logic [7:0]  tag;
    logic [15:0] size;
    logic [7:0]  pkt_type;
    logic [7:0]  src_rank;
    logic [15:0] dst_rank;
  } mpi_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ENV,
    ST_DRAIN_ENV,
    ST_REPLY_CTS,
    ST_WAIT_DATA,
    ST_PAYLOAD,
    ST_REPLY_FIN,
    ST_DROP
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mpi_hdr_match.sv
// Combinational header decode: compares a header beat against the expected
// packet type, our rank, the posted source rank and the protocol version.
module mpi_hdr_match
  import mpi_pkg::*;
(
  input  logic [63:0] hdr,
  input  logic [7:0]  exp_type,
  input  logic [15:0] local_rank,
  input  logic [7:0]  src,
  output logic        match,
  output logic [15:0] size
);

  mpi_hdr_t h;
  logic     unused_tag;

  assign h          = mpi_hdr_t'(hdr);
  assign unused_tag = ^h.tag;

  assign match = (h.pkt_type == exp_type)   &&
                 (h.dst_rank == local_rank) &&
                 (h.src_rank == src)        &&
                 (h.version  == MPI_VERSION);
  assign size  = h.size;

endmodule

// File: rtl/mpi_rx_rendezvous.sv
// Receive side of the MPI rendezvous protocol: matches the sync envelope,
// requests CLR2SND, streams the payload to the kernel and requests DONE/ERROR.
module mpi_rx_rendezvous
  import mpi_pkg::*;
#(
  parameter int DROP_CNT_W  = 16,
  parameter int MAX_BYTES_W = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [15:0]           local_rank,
  input  logic                  recv_req_valid,
  output logic                  recv_req_ready,
  input  logic [7:0]            recv_req_src,
  input  logic [63:0]           s_axis_data,
  input  logic [7:0]            s_axis_keep,
  input  logic                  s_axis_last,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  output logic [63:0]           m_axis_data,
  output logic [7:0]            m_axis_keep,
  output logic                  m_axis_last,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  reply_valid,
  input  logic                  reply_ready,
  output logic [7:0]            reply_type,
  output logic [15:0]           reply_dst_rank,
  output logic [15:0]           reply_size,
  output logic                  recv_done,
  output logic                  recv_error,
  output logic [DROP_CNT_W-1:0] drop_count
);

  state_t                 state_q, state_d, ret_q, ret_d;
  logic                   active_q;
  logic                   mid_frame_q;
  logic [7:0]             src_q;
  logic [MAX_BYTES_W-1:0] size_q, byte_cnt_q, cnt_sum;
  logic [MAX_BYTES_W:0]   cnt_wide;
  logic                   sat_q, sat_sum, fin_err;
  logic                   reply_valid_q;
  logic [7:0]             reply_type_q, reply_type_d;
  logic [15:0]            reply_size_q, reply_size_d;
  logic                   done_q, error_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;

  logic        s_ready, beat, hdr_beat, hdr_ok;
  logic [15:0] hdr_size;
  logic [7:0]  exp_type;
  logic        src_load, size_load, cnt_clr, cnt_upd, drop_inc;
  logic        reply_load, reply_clr, fin_accept;

  assign exp_type = (state_q == ST_WAIT_DATA) ? DATA : SYNC_ENV;

  mpi_hdr_match u_hdr_match (
    .hdr       (s_axis_data),
    .exp_type  (exp_type),
    .local_rank(local_rank),
    .src       (src_q),
    .match     (hdr_ok),
    .size      (hdr_size)
  );

  // active_q keeps both ready outputs low in the first cycle out of reset.
  always_comb begin
    // NOTE: the default branch gives s_ready a value in every state, so no latch is inferred.
    unique case (state_q)
      ST_IDLE, ST_WAIT_ENV, ST_DRAIN_ENV, ST_WAIT_DATA, ST_DROP: s_ready = active_q;
      ST_PAYLOAD: s_ready = m_axis_ready;
      default:    s_ready = 1'b0;
    endcase
  end

  assign beat     = s_axis_valid && s_ready;
  assign hdr_beat = beat && !mid_frame_q;

  // Byte counter sticks at all-ones; any overflow forces an error reply.
  assign cnt_wide = {1'b0, byte_cnt_q} + (MAX_BYTES_W+1)'(popcount8(s_axis_keep));
  assign cnt_sum  = cnt_wide[MAX_BYTES_W] ? '1 : cnt_wide[MAX_BYTES_W-1:0];
  assign sat_sum  = sat_q || cnt_wide[MAX_BYTES_W];
  assign fin_err  = sat_sum || (cnt_sum != size_q);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    src_load     = 1'b0;
    size_load    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_upd      = 1'b0;
    drop_inc     = 1'b0;
    reply_load   = 1'b0;
    reply_clr    = 1'b0;
    fin_accept   = 1'b0;
    reply_type_d = reply_type_q;
    reply_size_d = reply_size_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hdr_beat) drop_inc = 1'b1;
        if (recv_req_valid && active_q) begin
          src_load = 1'b1;
          // A frame still open after this cycle must be flushed before matching.
          if (beat ? !s_axis_last : mid_frame_q) begin
            state_d = ST_DROP;
            ret_d   = ST_WAIT_ENV;
          end else begin
            state_d = ST_WAIT_ENV;
          end
        end
      end

      ST_WAIT_ENV: begin
        if (hdr_beat) begin
          if (hdr_ok) begin
            size_load = 1'b1;
            if (s_axis_last) begin
              state_d      = ST_REPLY_CTS;
              reply_load   = 1'b1;
              reply_type_d = CLR2SND;
              reply_size_d = hdr_size;
            end else begin
              state_d = ST_DRAIN_ENV;
            end
          end else begin
            drop_inc = 1'b1;
            if (!s_axis_last) begin
              state_d = ST_DROP;
              ret_d   = ST_WAIT_ENV;
            end
          end
        end
      end

      ST_DRAIN_ENV: begin
        if (beat && s_axis_last) begin
          state_d      = ST_REPLY_CTS;
          reply_load   = 1'b1;
          reply_type_d = CLR2SND;
          reply_size_d = 16'(size_q);
        end
      end

      ST_REPLY_CTS: begin
        if (reply_valid_q && reply_ready) begin
          reply_clr = 1'b1;
          state_d   = ST_WAIT_DATA;
        end
      end

      ST_WAIT_DATA: begin
        if (hdr_beat) begin
          if (hdr_ok) begin
            size_load = 1'b1;
            cnt_clr   = 1'b1;
            if (s_axis_last) begin
              state_d      = ST_REPLY_FIN;
              reply_load   = 1'b1;
              reply_type_d = (hdr_size == 16'd0) ? DATA_TRANSMISSION_DONE : RECV_ERROR;
              reply_size_d = 16'd0;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            drop_inc = 1'b1;
            if (!s_axis_last) begin
              state_d = ST_DROP;
              ret_d   = ST_WAIT_DATA;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (beat) begin
          cnt_upd = 1'b1;
          if (s_axis_last) begin
            state_d      = ST_REPLY_FIN;
            reply_load   = 1'b1;
            reply_type_d = fin_err ? RECV_ERROR : DATA_TRANSMISSION_DONE;
            reply_size_d = 16'd0;
          end
        end
      end

      ST_REPLY_FIN: begin
        if (reply_valid_q && reply_ready) begin
          reply_clr  = 1'b1;
          fin_accept = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (beat && s_axis_last) state_d = ret_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      active_q    <= 1'b0;
      mid_frame_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      active_q <= 1'b1;
      if (beat) mid_frame_q <= !s_axis_last;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      src_q      <= '0;
      size_q     <= '0;
      byte_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (src_load)  src_q  <= recv_req_src;
      if (size_load) size_q <= MAX_BYTES_W'(hdr_size);
      if (cnt_clr) begin
        byte_cnt_q <= '0;
        sat_q      <= 1'b0;
      end else if (cnt_upd) begin
        byte_cnt_q <= cnt_sum;
        sat_q      <= sat_sum;
      end
    end
  end

  // Reply fields only change on load, so they hold while stalled by reply_ready.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      reply_valid_q <= 1'b0;
      reply_type_q  <= '0;
      reply_size_q  <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      if (reply_load) begin
        reply_valid_q <= 1'b1;
        reply_type_q  <= reply_type_d;
        reply_size_q  <= reply_size_d;
      end else if (reply_clr) begin
        reply_valid_q <= 1'b0;
      end
      done_q  <= fin_accept;
      error_q <= fin_accept && (reply_type_q == RECV_ERROR);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign recv_req_ready = active_q && (state_q == ST_IDLE);
  assign s_axis_ready   = s_ready;

  assign m_axis_valid = (state_q == ST_PAYLOAD) && s_axis_valid;
  assign m_axis_data  = s_axis_data;
  assign m_axis_keep  = s_axis_keep;
  assign m_axis_last  = s_axis_last;

  assign reply_valid    = reply_valid_q;
  assign reply_type     = reply_type_q;
  assign reply_size     = reply_size_q;
  assign reply_dst_rank = {8'd0, src_q};

  assign recv_done  = done_q;
  assign recv_error = error_q;
  assign drop_count = drop_cnt_q;

endmodule
